main_bus_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer sharing the multiplexed main bus (AddrData + rw) between NUM_REQ processor-side requesters. It accepts one burst request per requester, grants the bus to one requester at a time, and drives the address phase, BURST_LEN data beats and a read turnaround cycle. It sits between the processor interfaces and the memory-side bus, and is the only driver of AddrData on the master side.

---
 rtl/main_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_main_bus_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_bus_arbiter.sv
// Round-robin arbiter and burst sequencer for the multiplexed AddrData main bus.
// One requester owns the bus per burst: address cycle, BURST_LEN beats, then TURN after reads.
module main_bus_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned BUSWIDTH  = 16,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ-1:0]           req_we_i,
    input  logic [NUM_REQ*BUSWIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*BUSWIDTH-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [NUM_REQ-1:0]           beat_ack_o,
    output logic [NUM_REQ-1:0]           rd_valid_o,
    output logic [BUSWIDTH-1:0]          rd_data_o,
    output logic [NUM_REQ-1:0]           done_o,
    output logic [BUSWIDTH-1:0]          bus_ad_out_o,
    output logic                         bus_ad_oe_o,
    input  logic [BUSWIDTH-1:0]          bus_ad_in_i,
    output logic                         bus_rw_o,
    output logic                         bus_as_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(BURST_LEN);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StTurn} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     win_q, win_d, last_q, last_d;
    logic [IdxW-1:0]     pick_idx, cand;
    logic                pick_valid;
    logic                we_q, we_d;
    logic [BUSWIDTH-1:0] addr_q, addr_d, pick_addr, wdata_sel, rd_data_q;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  win_oh, rd_valid_q;

    assign win_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdxW'((32'(last_q) + k) % NUM_REQ);
            if (!pick_valid && req_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_addr = '0;
        wdata_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IdxW'(i) == pick_idx) pick_addr = req_addr_i[i*BUSWIDTH +: BUSWIDTH];
            if (IdxW'(i) == win_q)    wdata_sel = req_wdata_i[i*BUSWIDTH +: BUSWIDTH];
        end
    end

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        last_d       = last_q;
        we_d         = we_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        gnt_o        = '0;
        beat_ack_o   = '0;
        done_o       = '0;
        bus_ad_out_o = '0;
        bus_ad_oe_o  = 1'b0;
        bus_rw_o     = 1'b1;
        bus_as_o     = 1'b0;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    win_d   = pick_idx;
                    we_d    = req_we_i[pick_idx];
                    addr_d  = pick_addr;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                gnt_o        = win_oh;
                bus_ad_out_o = addr_q;
                bus_ad_oe_o  = 1'b1;
                bus_as_o     = 1'b1;
                bus_rw_o     = ~we_q;
                cnt_d        = '0;
                state_d      = StData;
            end
            StData: begin
                gnt_o = win_oh;
                cnt_d = cnt_q + 1'b1;
                if (we_q) begin
                    bus_ad_out_o = wdata_sel;
                    bus_ad_oe_o  = 1'b1;
                    beat_ack_o   = win_oh;
                end
                if (cnt_q == CntW'(BURST_LEN - 1)) begin
                    done_o  = win_oh;
                    last_d  = win_q;
                    state_d = we_q ? StIdle : StTurn;
                end
            end
            StTurn: begin
                // Master stays off the bus one cycle so memory can release it.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            win_q      <= '0;
            last_q     <= IdxW'(NUM_REQ - 1);
            we_q       <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            if (state_q == StData && !we_q) begin
                rd_data_q  <= bus_ad_in_i;
                rd_valid_q <= win_oh;
            end else begin
                rd_valid_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Randomised and directed bench for main_bus_arbiter, checked every cycle against a
// transaction-schedule model (each grant expands into a list of expected bus cycles).
module tb_main_bus_arbiter;
    localparam int N = 2;
    localparam int W = 16;
    localparam int L = 4;
    localparam int KAddr = 1;
    localparam int KData = 2;
    localparam int KTurn = 3;

    typedef struct {
        int           kind;
        int           idx;
        bit           we;
        logic [W-1:0] addr;
        int           beat;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0]   req, req_we, gnt, beat_ack, rd_valid, done;
    logic [N*W-1:0] req_addr, req_wdata;
    logic [W-1:0]   rd_data, bus_ad_out, bus_ad_in;
    logic           bus_ad_oe, bus_rw, bus_as;

    main_bus_arbiter #(.NUM_REQ(N), .BUSWIDTH(W), .BURST_LEN(L)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .gnt_o        (gnt),
        .beat_ack_o   (beat_ack),
        .rd_valid_o   (rd_valid),
        .rd_data_o    (rd_data),
        .done_o       (done),
        .bus_ad_out_o (bus_ad_out),
        .bus_ad_oe_o  (bus_ad_oe),
        .bus_ad_in_i  (bus_ad_in),
        .bus_rw_o     (bus_rw),
        .bus_as_o     (bus_as)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Requester models
    bit           pend [N];
    bit           arm [N];
    bit           we_r [N];
    logic [W-1:0] addr_r [N];
    logic [W-1:0] wd [N][L];
    int           bidx [N];
    int           gap [N];
    bit           auto_on = 0;
    int           gap_max = 0;
    int           drop_pct = 0;
    bit           mem_seq = 0;

    // Reference model and observation logs
    rec_t         exp_q[$];
    int           m_last;
    bit           prev_rd;
    int           prev_idx;
    logic [W-1:0] prev_bus;
    int           cur_kind, cur_beat;
    logic [N-1:0] obs_ack, obs_done, obs_gnt;
    logic         obs_as;
    int           gnt_log[$];
    logic [W-1:0] rd_log[$];
    int           done_obs [N];
    int           gnt_cnt [N];
    int           beat_cnt [N];

    task automatic rand_params(input int i);
        we_r[i]   = 1'($urandom_range(0, 1));
        addr_r[i] = W'($urandom);
        for (int b = 0; b < L; b++) wd[i][b] = W'($urandom);
    endtask

    task automatic set_burst(input int i, input bit we, input logic [W-1:0] a,
                             input logic [W-1:0] d0, input logic [W-1:0] d1,
                             input logic [W-1:0] d2, input logic [W-1:0] d3);
        we_r[i] = we;  addr_r[i] = a;
        wd[i][0] = d0; wd[i][1] = d1; wd[i][2] = d2; wd[i][3] = d3;
        arm[i] = 1'b1;
    endtask

    // One bus cycle: requesters react, model predicts, every output is compared.
    task automatic step();
        logic [N-1:0] e_gnt, e_ack, e_done, e_rv;
        logic         e_oe, e_rw, e_as;
        logic [W-1:0] e_ad, e_rd;
        rec_t         r;
        int           c;
        bit           found;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (obs_ack[i]) bidx[i]++;
            if (obs_done[i]) begin
                pend[i] = 0; req[i] = 1'b0; gap[i] = $urandom_range(0, gap_max);
            end else if (arm[i]) begin
                arm[i] = 0; pend[i] = 1; req[i] = 1'b1; bidx[i] = 0;
            end else if (auto_on && !pend[i]) begin
                if (gap[i] == 0) begin
                    rand_params(i); pend[i] = 1; req[i] = 1'b1; bidx[i] = 0;
                end else gap[i]--;
            end else if (drop_pct > 0 && pend[i] && req[i] && obs_gnt[i] && !obs_as &&
                         $urandom_range(0, 99) < drop_pct) begin
                req[i] = 1'b0;
            end
            req_we[i]            = we_r[i];
            req_addr[i*W +: W]   = addr_r[i];
            req_wdata[i*W +: W]  = wd[i][(bidx[i] < L) ? bidx[i] : L - 1];
        end
        bus_ad_in = W'($urandom);
        if (mem_seq && exp_q.size() > 0 && exp_q[0].kind == KData && !exp_q[0].we)
            bus_ad_in = 16'h00A0 + 16'(exp_q[0].beat);
        #1;
        e_gnt = '0; e_ack = '0; e_done = '0; e_rv = '0;
        e_oe = 1'b0; e_rw = 1'b1; e_as = 1'b0; e_ad = '0; e_rd = '0;
        if (prev_rd) begin e_rv[prev_idx] = 1'b1; e_rd = prev_bus; end
        cur_kind = 0; cur_beat = -1;
        if (exp_q.size() == 0) begin
            prev_rd = 0;
            found = 0; c = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && req[(m_last + k) % N]) begin found = 1; c = (m_last + k) % N; end
            end
            if (found) begin
                exp_q.push_back('{KAddr, c, we_r[c], addr_r[c], 0});
                for (int b = 0; b < L; b++) exp_q.push_back('{KData, c, we_r[c], addr_r[c], b});
                if (!we_r[c]) exp_q.push_back('{KTurn, c, 1'b0, addr_r[c], 0});
            end
        end else begin
            r = exp_q.pop_front();
            cur_kind = r.kind; cur_beat = r.beat;
            if (r.kind == KAddr) begin
                e_gnt[r.idx] = 1'b1; e_oe = 1'b1; e_as = 1'b1; e_rw = ~r.we; e_ad = r.addr;
            end else if (r.kind == KData) begin
                e_gnt[r.idx] = 1'b1;
                if (r.we) begin e_oe = 1'b1; e_ad = wd[r.idx][r.beat]; e_ack[r.idx] = 1'b1; end
                if (r.beat == L - 1) begin e_done[r.idx] = 1'b1; m_last = r.idx; end
            end
            prev_rd = (r.kind == KData && !r.we); prev_idx = r.idx; prev_bus = bus_ad_in;
        end
        checks++; if (gnt !== e_gnt) begin failures++;
            $display("FAIL gnt t=%0t got=%b exp=%b", $time, gnt, e_gnt); end
        checks++; if (beat_ack !== e_ack) begin failures++;
            $display("FAIL beat_ack t=%0t got=%b exp=%b", $time, beat_ack, e_ack); end
        checks++; if (done !== e_done) begin failures++;
            $display("FAIL done t=%0t got=%b exp=%b", $time, done, e_done); end
        checks++; if (rd_valid !== e_rv) begin failures++;
            $display("FAIL rd_valid t=%0t got=%b exp=%b", $time, rd_valid, e_rv); end
        checks++; if (bus_ad_oe !== e_oe) begin failures++;
            $display("FAIL bus_ad_oe t=%0t got=%b exp=%b", $time, bus_ad_oe, e_oe); end
        checks++; if (bus_rw !== e_rw) begin failures++;
            $display("FAIL bus_rw t=%0t got=%b exp=%b", $time, bus_rw, e_rw); end
        checks++; if (bus_as !== e_as) begin failures++;
            $display("FAIL bus_as t=%0t got=%b exp=%b", $time, bus_as, e_as); end
        if (e_oe) begin
            checks++; if (bus_ad_out !== e_ad) begin failures++;
                $display("FAIL bus_ad_out t=%0t got=%h exp=%h", $time, bus_ad_out, e_ad); end
        end
        if (|e_rv) begin
            checks++; if (rd_data !== e_rd) begin failures++;
                $display("FAIL rd_data t=%0t got=%h exp=%h", $time, rd_data, e_rd); end
        end
        obs_ack = beat_ack; obs_done = done; obs_gnt = gnt; obs_as = bus_as;
        for (int i = 0; i < N; i++) begin
            if (bus_as && gnt[i]) gnt_log.push_back(i);
            done_obs[i] += int'(done[i]);
            gnt_cnt[i]  += int'(gnt[i]);
            beat_cnt[i] += int'(beat_ack[i]) + int'(rd_valid[i]);
        end
        if (rd_valid[1]) rd_log.push_back(rd_data);
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit busy;
        for (int n = 0; n < budget; n++) begin
            step();
            busy = (exp_q.size() != 0) || prev_rd;
            for (int i = 0; i < N; i++) busy |= pend[i] | arm[i];
            if (!busy) return;
        end
        failures++;
        $display("FAIL %s timeout after %0d cycles", name, budget);
    endtask

    task automatic reset_model();
        exp_q.delete(); m_last = N - 1; prev_rd = 0;
        obs_ack = '0; obs_done = '0; obs_gnt = '0; obs_as = 1'b0;
        for (int i = 0; i < N; i++) bidx[i] = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; bus_ad_in = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; arm[i] = 0; gap[i] = 0; done_obs[i] = 0; gnt_cnt[i] = 0;
            beat_cnt[i] = 0; we_r[i] = 0; addr_r[i] = '0;
            for (int b = 0; b < L; b++) wd[i][b] = '0;
        end
        reset_model();
        #12;
        checks++; if ({gnt, beat_ack, rd_valid, done} !== '0) begin failures++;
            $display("FAIL reset_pulses got=%b exp=0", {gnt, beat_ack, rd_valid, done}); end
        checks++; if ({rd_data, bus_ad_out} !== '0) begin failures++;
            $display("FAIL reset_data got=%h exp=0", {rd_data, bus_ad_out}); end
        checks++; if ({bus_ad_oe, bus_rw, bus_as} !== 3'b010) begin failures++;
            $display("FAIL reset_ctrl got=%b exp=010", {bus_ad_oe, bus_rw, bus_as}); end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int n = 0; n < 3; n++) step();
    endtask

    task automatic test_single_write();
        int n0 = gnt_log.size();
        int d0 = done_obs[0];
        int g0 = gnt_cnt[0];
        set_burst(0, 1'b1, 16'h3A10, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        wait_idle(40, "single_write");
        checks++; if (gnt_log.size() != n0 + 1 || gnt_log[n0] != 0) begin failures++;
            $display("FAIL write_winner grants=%0d exp=1 to requester 0", gnt_log.size() - n0); end
        checks++; if (done_obs[0] != d0 + 1) begin failures++;
            $display("FAIL write_done got=%0d exp=1", done_obs[0] - d0); end
        checks++; if (gnt_cnt[0] != g0 + 1 + L) begin failures++;
            $display("FAIL write_gnt_cycles got=%0d exp=%0d", gnt_cnt[0] - g0, 1 + L); end
    endtask

    task automatic test_single_read();
        rd_log.delete();
        mem_seq = 1;
        set_burst(1, 1'b0, 16'h0123, 16'h0, 16'h0, 16'h0, 16'h0);
        wait_idle(40, "single_read");
        mem_seq = 0;
        checks++; if (rd_log.size() != L) begin failures++;
            $display("FAIL read_count got=%0d exp=%0d", rd_log.size(), L); end
        for (int b = 0; b < rd_log.size() && b < L; b++) begin
            checks++; if (rd_log[b] !== 16'h00A0 + 16'(b)) begin failures++;
                $display("FAIL read_beat%0d got=%h exp=%h", b, rd_log[b], 16'h00A0 + 16'(b)); end
        end
    endtask

    task automatic test_contention();
        int n0 = gnt_log.size();
        int first = (m_last + 1) % N;
        int n;
        for (int i = 0; i < N; i++) begin rand_params(i); arm[i] = 1'b1; end
        auto_on = 1; gap_max = 0;
        for (n = 0; n < 300 && gnt_log.size() < n0 + 6; n++) step();
        auto_on = 0;
        wait_idle(100, "contention_drain");
        checks++; if (gnt_log.size() < n0 + 6) begin failures++;
            $display("FAIL contention_grants got=%0d exp>=6", gnt_log.size() - n0); end
        for (int k = 0; k < 6 && n0 + k < gnt_log.size(); k++) begin
            checks++; if (gnt_log[n0 + k] != (first + k) % N) begin failures++;
                $display("FAIL contention_order%0d got=%0d exp=%0d", k, gnt_log[n0 + k],
                         (first + k) % N); end
        end
    endtask

    task automatic test_reset_mid();
        int n0, d1;
        bit hit = 0;
        set_burst(1, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        for (int n = 0; n < 20 && !hit; n++) begin
            step();
            if (cur_kind == KAddr) set_burst(0, 1'b1, 16'h5000, 16'h0A0A, 16'h0B0B, 16'h0C0C,
                                             16'h0D0D);
            hit = (cur_kind == KData && cur_beat == 1);
        end
        if (!hit) begin failures++; $display("FAIL reset_mid never reached beat 2"); end
        d1 = done_obs[1];
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({gnt, beat_ack, rd_valid, done} !== '0) begin failures++;
            $display("FAIL rstmid_pulses got=%b exp=0", {gnt, beat_ack, rd_valid, done}); end
        checks++; if ({bus_ad_oe, bus_rw, bus_as} !== 3'b010 || bus_ad_out !== '0) begin
            failures++;
            $display("FAIL rstmid_ctrl got=%b/%h exp=010/0", {bus_ad_oe, bus_rw, bus_as},
                     bus_ad_out); end
        reset_model();
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        n0 = gnt_log.size();
        wait_idle(60, "reset_mid");
        checks++; if (gnt_log.size() != n0 + 2 || gnt_log[n0] != 0) begin failures++;
            $display("FAIL rstmid_first_grant grants=%0d exp 2 starting at requester 0",
                     gnt_log.size() - n0); end
        checks++; if (done_obs[1] != d1 + 1) begin failures++;
            $display("FAIL rstmid_done got=%0d exp=1", done_obs[1] - d1); end
    endtask

    task automatic test_req_drop();
        int d1 = done_obs[1];
        int b1 = beat_cnt[1];
        bit dropped = 0;
        rand_params(1);
        arm[1] = 1'b1;
        for (int n = 0; n < 30 && (pend[1] || arm[1] || !dropped); n++) begin
            step();
            if (!dropped && gnt[1] === 1'b1 && bus_as === 1'b0) begin
                req[1] = 1'b0; dropped = 1;
            end
        end
        wait_idle(20, "req_drop");
        checks++; if (done_obs[1] != d1 + 1) begin failures++;
            $display("FAIL drop_done got=%0d exp=1", done_obs[1] - d1); end
        checks++; if (beat_cnt[1] != b1 + L) begin failures++;
            $display("FAIL drop_beats got=%0d exp=%0d", beat_cnt[1] - b1, L); end
    endtask

    task automatic test_random();
        int n0 = gnt_log.size();
        auto_on = 1; gap_max = 3; drop_pct = 15;
        for (int n = 0; n < 400; n++) step();
        auto_on = 0; drop_pct = 0;
        wait_idle(100, "random_drain");
        checks++; if (gnt_log.size() - n0 < 20) begin failures++;
            $display("FAIL random_grants got=%0d exp>=20", gnt_log.size() - n0); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_reset_mid();
        test_req_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
